// File: rtl/serial_adder.sv
// serial_adder: bit-serial add / subtract / xnor / xor unit, LSB first.
//
// Operands are captured on start in IDLE, then one bit per cycle is
// processed for WIDTH cycles in RUN. Results are loaded into the output
// registers on the RUN->DONE edge and held until the next completion or
// reset. done pulses for the single DONE cycle.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   start  - begin an operation (sampled only in IDLE)
//   mode   - 00 add, 01 subtract (a-b), 10 bitwise xnor, 11 bitwise xor
//   a, b   - operands, sampled with start
//   busy   - high while in RUN
//   done   - one-cycle pulse in DONE
//   sum    - result
//   cout   - carry out (subtract: 1 = no borrow); 0 for bitwise modes
//   ovf    - two's-complement signed overflow; 0 for bitwise modes
//   eq     - a == b, valid in every mode
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             eq
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_XNOR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [1:0]       mode_q, mode_d;
    logic             carry_q, carry_d;
    logic             eq_acc_q, eq_acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             eq_q, eq_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Per-bit datapath for the current LSB of the operand shifters
    logic             bit_a;
    logic             bit_b;
    logic             bit_b_eff;
    logic             bit_arith;
    logic             bit_s;
    logic             bit_eq;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_shifted;

    // One-bit full adder / logic slice
    always_comb begin
        bit_a       = a_sh_q[0];
        bit_b       = b_sh_q[0];
        bit_arith   = (mode_q == MODE_ADD) || (mode_q == MODE_SUB);
        // Subtract is a + ~b + 1: invert b here, the +1 is the carry seed
        bit_b_eff   = bit_b ^ (mode_q == MODE_SUB);
        bit_eq      = ~(bit_a ^ bit_b);
        bit_s       = 1'b0;
        carry_nxt   = 1'b0;
        if (bit_arith) begin
            bit_s     = bit_a ^ bit_b_eff ^ carry_q;
            carry_nxt = (bit_a & bit_b_eff) | (bit_a & carry_q) | (bit_b_eff & carry_q);
        end else if (mode_q == MODE_XNOR) begin
            bit_s = ~(bit_a ^ bit_b);
        end else begin
            bit_s = bit_a ^ bit_b;
        end
        // New bit enters at the MSB so bit 0 ends at the LSB after WIDTH shifts
        res_shifted = {bit_s, res_sh_q[WIDTH-1:1]};
    end

    // Next-state and register-update logic
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        mode_d   = mode_q;
        carry_d  = carry_q;
        eq_acc_d = eq_acc_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        eq_d     = eq_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    mode_d   = mode;
                    carry_d  = (mode == MODE_SUB);
                    eq_acc_d = 1'b1;
                    cnt_d    = '0;
                end
            end

            RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = res_shifted;
                carry_d  = carry_nxt;
                eq_acc_d = eq_acc_q & bit_eq;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last bit: results include this cycle's slice output
                    state_d = DONE;
                    cnt_d   = '0;
                    sum_d   = res_shifted;
                    eq_d    = eq_acc_q & bit_eq;
                    // carry_q here is the carry into the MSB
                    cout_d  = bit_arith ? carry_nxt : 1'b0;
                    ovf_d   = bit_arith ? (carry_q ^ carry_nxt) : 1'b0;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            mode_q   <= '0;
            carry_q  <= 1'b0;
            eq_acc_q <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            eq_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            mode_q   <= mode_d;
            carry_q  <= carry_d;
            eq_acc_q <= eq_acc_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            eq_q     <= eq_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder (WIDTH=8)
// against an arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         eq;

    int n_cmp;
    int n_err;

    // Values the result outputs should currently be holding
    logic [W-1:0] h_sum;
    logic         h_cout;
    logic         h_ovf;
    logic         h_eq;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .mode (mode),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf),
        .eq   (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain two's-complement arithmetic on whole words
    task automatic ref_model(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                             output logic [W-1:0] s, output logic c, output logic o,
                             output logic e);
        logic [W:0] full;
        e = (av == bv);
        c = 1'b0;
        o = 1'b0;
        case (m)
            2'b00: begin
                full = {1'b0, av} + {1'b0, bv};
                s    = full[W-1:0];
                c    = full[W];
                o    = (av[W-1] == bv[W-1]) && (s[W-1] != av[W-1]);
            end
            2'b01: begin
                full = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
                s    = full[W-1:0];
                c    = full[W];
                o    = (av[W-1] != bv[W-1]) && (s[W-1] != av[W-1]);
            end
            2'b10:   s = ~(av ^ bv);
            default: s = av ^ bv;
        endcase
    endtask

    task automatic check_held(input string tag);
        check({tag, "_sum"},  64'(sum),  64'(h_sum));
        check({tag, "_cout"}, 64'(cout), 64'(h_cout));
        check({tag, "_ovf"},  64'(ovf),  64'(h_ovf));
        check({tag, "_eq"},   64'(eq),   64'(h_eq));
    endtask

    // Called at a negedge in IDLE (or right after reset). Launches one
    // operation and follows it to DONE. glitch pulses start with other
    // operands mid-RUN; abort_at>0 resets during that RUN cycle.
    task automatic do_op(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit glitch, input int abort_at);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        logic         ee;
        int           busy_cnt;
        int           done_at;
        ref_model(m, av, bv, es, ec, eo, ee);
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_done", 64'(done), 64'(0));
        start    = 1'b1;
        mode     = m;
        a        = av;
        b        = bv;
        busy_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= int'(W) + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            mode  = 2'($urandom);
            if (glitch && k == 3) start = 1'b1;
            if (busy) busy_cnt++;
            if (done && done_at == 0) done_at = k;
            if (k <= int'(W)) begin
                check("run_busy", 64'(busy), 64'(1));
                check("run_done", 64'(done), 64'(0));
                check_held("run_hold");
            end else begin
                check("done_busy", 64'(busy), 64'(0));
                check("done_done", 64'(done), 64'(1));
                h_sum  = es;
                h_cout = ec;
                h_ovf  = eo;
                h_eq   = ee;
                check_held("result");
            end
            if (k == abort_at) begin
                start = 1'b0;
                rst   = 1'b1;
                @(negedge clk);
                rst    = 1'b0;
                h_sum  = '0;
                h_cout = 1'b0;
                h_ovf  = 1'b0;
                h_eq   = 1'b0;
                check("abort_busy", 64'(busy), 64'(0));
                check("abort_done", 64'(done), 64'(0));
                check_held("abort");
                return;
            end
        end
        check("busy_cycles", 64'(busy_cnt), 64'(W));
        check("done_cycle", 64'(done_at), 64'(W + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        h_sum  = '0;
        h_cout = 1'b0;
        h_ovf  = 1'b0;
        h_eq   = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        mode   = 2'b00;
        a      = '0;
        b      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check_held("rst");
        rst = 1'b0;

        // Directed corner cases
        do_op(2'b00, 8'hFF, 8'h01, 1'b0, 0);
        @(negedge clk);
        do_op(2'b01, 8'h05, 8'h05, 1'b0, 0);
        @(negedge clk);
        do_op(2'b00, 8'h7F, 8'h01, 1'b0, 0);
        @(negedge clk);
        do_op(2'b01, 8'h80, 8'h01, 1'b0, 0);
        @(negedge clk);
        do_op(2'b10, 8'hF0, 8'hCC, 1'b0, 0);
        @(negedge clk);
        do_op(2'b11, 8'hF0, 8'hCC, 1'b0, 0);
        @(negedge clk);
        do_op(2'b00, 8'h12, 8'h34, 1'b1, 0);
        @(negedge clk);
        do_op(2'b00, 8'h3C, 8'h41, 1'b0, 4);
        do_op(2'b01, 8'h10, 8'h20, 1'b0, 0);

        // Randomized operations, mixing back-to-back and idle gaps
        for (int i = 0; i < 60; i++) begin
            logic [1:0]   rm;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rm = 2'($urandom);
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            @(negedge clk);
            repeat ($urandom_range(0, 2)) begin
                check("gap_busy", 64'(busy), 64'(0));
                check("gap_done", 64'(done), 64'(0));
                @(negedge clk);
            end
            if ($urandom_range(0, 9) == 0) begin
                do_op(rm, ra, rb, 1'b0, int'($urandom_range(1, W)));
            end else begin
                do_op(rm, ra, rb, $urandom_range(0, 3) == 0, 0);
            end
        end

        @(negedge clk);
        check("final_done", 64'(done), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range is 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port mode, input, 2 bits: operation select; 00 add, 01 subtract (a-b), 10 bitwise xnor, 11 bitwise xor.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands, sampled together with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.
REQ-009 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-010 The block SHALL have port cout, output, 1 bit: carry out; for subtract, 1 means no borrow.
REQ-011 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-012 The block SHALL have port eq, output, 1 bit: a equals b, valid in every mode.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions: IDLE->RUN on start=1; RUN->DONE after exactly WIDTH RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-014 On start in IDLE, the block SHALL capture a, b and mode into internal shift/mode registers.
- Carry register initialised to 1 for mode 01, otherwise 0.
- eq accumulator initialised to 1.
- Bit counter cleared to 0.
REQ-015 Each RUN cycle SHALL process one bit, LSB first: b'=b_i XOR (mode==01); s_i = a_i XOR b' XOR c; c_next = majority(a_i, b', c).
REQ-016 For modes 10 and 11, s_i SHALL be a_i XNOR b_i and a_i XOR b_i respectively, and the carry register SHALL be held at 0.
REQ-017 In every mode, each RUN cycle SHALL AND the eq accumulator with (a_i XNOR b_i).
REQ-018 Each result bit SHALL shift into the MSB of the result shift register, so that after WIDTH shifts bit 0 sits at the LSB.
REQ-019 The bit counter SHALL be ceil(log2(WIDTH)) bits wide or more, incrementing 0..WIDTH-1; RUN SHALL exit when the counter equals WIDTH-1, with no wrap into a further cycle.
REQ-020 On the RUN->DONE edge, the block SHALL load sum, cout, ovf and eq from the internal registers.
- ovf = carry into MSB XOR carry out of MSB, for modes 00 and 01.
- ovf = 0 and cout = 0 for modes 10 and 11.
REQ-021 done SHALL be 1 only in DONE; busy SHALL be 1 only in RUN; neither output SHALL be high in IDLE.
REQ-022 Latency: with start sampled high at edge T, busy SHALL be high for cycles T+1..T+WIDTH, and done and the new results SHALL be visible in cycle T+WIDTH+1.
REQ-023 sum, cout, ovf and eq SHALL hold their last loaded values until the next RUN->DONE edge or reset, and SHALL NOT change during RUN.
REQ-024 start SHALL be ignored in RUN and DONE, with no queueing; changes on a, b or mode during RUN SHALL NOT affect the operation in flight.
REQ-025 Back-to-back operation: start high in the first IDLE cycle after DONE SHALL be accepted, giving a throughput of one operation per WIDTH+2 cycles.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL enter IDLE and clear busy, done, sum, cout, ovf, eq, the bit counter, the carry register and the shift registers to 0.
REQ-027 rst SHALL take priority over start and over every state transition.
REQ-028 A reset asserted mid-RUN SHALL abort the operation with no done pulse, and the block SHALL accept start on the first edge after rst deasserts.

Verification (WIDTH=8)
REQ-029 The bench SHALL check add overflow: mode 00, a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0, eq=0, done pulse exactly 9 cycles after the start edge, busy high for exactly 8 cycles.
REQ-030 The bench SHALL check subtract of equal operands: mode 01, a=0x05, b=0x05 -> sum=0x00, cout=1, ovf=0, eq=1.
REQ-031 The bench SHALL check signed overflow: mode 00, a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0; then mode 01, a=0x80, b=0x01 -> sum=0x7F, ovf=1, cout=1.
REQ-032 The bench SHALL check bitwise modes: mode 10, a=0xF0, b=0xCC -> sum=0xC3, cout=0; mode 11 with the same operands -> sum=0x3C, eq=0.
REQ-033 The bench SHALL check start while busy: start pulsed during RUN with different operands -> ignored, and the original result is delivered on schedule.
REQ-034 The bench SHALL check reset mid-operation: rst for 1 cycle at RUN cycle 4 -> no done pulse, all outputs 0; a new start on the next edge completes normally.
